// File: rtl/multi_timer.sv
// multi_timer: CH independent H:M:S countdown channels sharing one seconds
// prescaler, driven by a six-button UI (browse / set). Outputs are the
// selected channel's fields, a digit blink mask and per-channel alarms.
// Optional feature macro: MULTI_TIMER_REPEAT_EN (auto-reload from preset at expiry).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// UI_BROWSE | field 0; navigate channels, start / pause / clear channel sel
// UI_SET    | field 1..3; channel sel stopped, edit sec / min / hour
module multi_timer #(
  parameter int CH       = 4,
  parameter int TICK_DIV = 1000000,
  parameter int HOUR_MAX = 99,
  localparam int SW      = $clog2(CH),
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          enter,
  input  logic          esc,
  output logic [SW-1:0] sel,
  output logic [6:0]    disp_hour,
  output logic [5:0]    disp_min,
  output logic [5:0]    disp_sec,
  output logic [1:0]    field,
  output logic [5:0]    blink_mask,
  output logic          norm,
  output logic [CH-1:0] running,
  output logic [CH-1:0] alm
);

  typedef enum logic {UI_BROWSE, UI_SET} ui_t;

  ui_t           ui_q, ui_n;
  logic [SW-1:0] sel_n;
  logic [1:0]    field_n;
  logic [CH-1:0] running_n, alm_n;
  logic [6:0]    hour_q [CH];
  logic [6:0]    hour_n [CH];
  logic [5:0]    min_q  [CH];
  logic [5:0]    min_n  [CH];
  logic [5:0]    sec_q  [CH];
  logic [5:0]    sec_n  [CH];
`ifdef MULTI_TIMER_REPEAT_EN
  logic [6:0]    phour_q [CH];
  logic [6:0]    phour_n [CH];
  logic [5:0]    pmin_q  [CH];
  logic [5:0]    pmin_n  [CH];
  logic [5:0]    psec_q  [CH];
  logic [5:0]    psec_n  [CH];
`endif
  logic [5:0]    btn, btn_prev, press;
  logic          p_esc, p_enter, p_right, p_left, p_up, p_down;
  logic [PW-1:0] pre_q;
  logic          tick;
  logic          clr_sel;

  assign btn   = {esc, enter, right, left, up, down};
  assign press = btn & ~btn_prev;
  assign tick  = (pre_q == '0);

  // One press per cycle: esc > enter > right > left > up > down.
  always_comb begin
    p_esc   = press[5];
    p_enter = press[4] & ~press[5];
    p_right = press[3] & ~|press[5:4];
    p_left  = press[2] & ~|press[5:3];
    p_up    = press[1] & ~|press[5:2];
    p_down  = press[0] & ~|press[5:1];
  end

  // Next-state: channel ticks first, then UI action on sel overrides, then mode clear.
  always_comb begin
    ui_n      = ui_q;
    sel_n     = sel;
    field_n   = field;
    running_n = running;
    alm_n     = alm;
    clr_sel   = 1'b0;
    for (int i = 0; i < CH; i++) begin
      hour_n[i] = hour_q[i];
      min_n[i]  = min_q[i];
      sec_n[i]  = sec_q[i];
`ifdef MULTI_TIMER_REPEAT_EN
      phour_n[i] = phour_q[i];
      pmin_n[i]  = pmin_q[i];
      psec_n[i]  = psec_q[i];
`endif
    end

    for (int i = 0; i < CH; i++) begin
      if (tick && running[i]) begin
        if (sec_q[i] != 6'd0) begin
          sec_n[i] = sec_q[i] - 6'd1;
        end else begin
          sec_n[i] = 6'd59;
          if (min_q[i] != 6'd0) begin
            min_n[i] = min_q[i] - 6'd1;
          end else begin
            min_n[i]  = 6'd59;
            hour_n[i] = hour_q[i] - 7'd1;
          end
        end
        // A running channel is never 0, so reaching zero means it was 00:00:01.
        if (hour_q[i] == 7'd0 && min_q[i] == 6'd0 && sec_q[i] == 6'd1) begin
          alm_n[i] = 1'b1;
`ifdef MULTI_TIMER_REPEAT_EN
          if ({phour_q[i], pmin_q[i], psec_q[i]} != '0) begin
            hour_n[i] = phour_q[i];
            min_n[i]  = pmin_q[i];
            sec_n[i]  = psec_q[i];
          end else begin
            running_n[i] = 1'b0;
          end
`else
          running_n[i] = 1'b0;
`endif
        end
      end
    end

    if (ui_q == UI_BROWSE) begin
      if (p_esc) begin
        clr_sel = 1'b1;
      end else if (p_enter) begin
        if (running[sel]) begin
          running_n[sel] = 1'b0;
          alm_n[sel]     = alm[sel];
          hour_n[sel]    = hour_q[sel];
          min_n[sel]     = min_q[sel];
          sec_n[sel]     = sec_q[sel];
        end else begin
          ui_n    = UI_SET;
          field_n = 2'd1;
        end
      end else if (p_right) begin
        if (!running[sel] && {hour_q[sel], min_q[sel], sec_q[sel]} != '0)
          running_n[sel] = 1'b1;
      end else if (p_up) begin
        sel_n = (sel == SW'(CH - 1)) ? '0 : sel + SW'(1);
      end else if (p_down) begin
        sel_n = (sel == '0) ? SW'(CH - 1) : sel - SW'(1);
      end
    end else begin
      if (p_esc) begin
        clr_sel = 1'b1;
        ui_n    = UI_BROWSE;
        field_n = 2'd0;
      end else if (p_enter) begin
`ifdef MULTI_TIMER_REPEAT_EN
        phour_n[sel] = hour_q[sel];
        pmin_n[sel]  = min_q[sel];
        psec_n[sel]  = sec_q[sel];
`endif
        ui_n    = UI_BROWSE;
        field_n = 2'd0;
      end else if (p_right) begin
        field_n = (field == 2'd1) ? 2'd3 : field - 2'd1;
      end else if (p_left) begin
        field_n = (field == 2'd3) ? 2'd1 : field + 2'd1;
      end else if (p_up) begin
        case (field)
          2'd1:    sec_n[sel]  = (sec_q[sel] == 6'd59) ? 6'd0 : sec_q[sel] + 6'd1;
          2'd2:    min_n[sel]  = (min_q[sel] == 6'd59) ? 6'd0 : min_q[sel] + 6'd1;
          default: hour_n[sel] = (hour_q[sel] == 7'(HOUR_MAX)) ? 7'd0 : hour_q[sel] + 7'd1;
        endcase
      end else if (p_down) begin
        case (field)
          2'd1:    sec_n[sel]  = (sec_q[sel] == 6'd0) ? 6'd59 : sec_q[sel] - 6'd1;
          2'd2:    min_n[sel]  = (min_q[sel] == 6'd0) ? 6'd59 : min_q[sel] - 6'd1;
          default: hour_n[sel] = (hour_q[sel] == 7'd0) ? 7'(HOUR_MAX) : hour_q[sel] - 7'd1;
        endcase
      end
    end

    if (clr_sel) begin
      running_n[sel] = 1'b0;
      alm_n[sel]     = 1'b0;
      hour_n[sel]    = 7'd0;
      min_n[sel]     = 6'd0;
      sec_n[sel]     = 6'd0;
`ifdef MULTI_TIMER_REPEAT_EN
      phour_n[sel] = 7'd0;
      pmin_n[sel]  = 6'd0;
      psec_n[sel]  = 6'd0;
`endif
    end

    if (!mode) begin
      ui_n      = UI_BROWSE;
      sel_n     = '0;
      field_n   = 2'd0;
      running_n = '0;
      alm_n     = '0;
      for (int i = 0; i < CH; i++) begin
        hour_n[i] = 7'd0;
        min_n[i]  = 6'd0;
        sec_n[i]  = 6'd0;
`ifdef MULTI_TIMER_REPEAT_EN
        phour_n[i] = 7'd0;
        pmin_n[i]  = 6'd0;
        psec_n[i]  = 6'd0;
`endif
      end
    end
  end

  // Seconds prescaler: down-counter, tick on terminal count, restarts when mode is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pre_q <= PW'(TICK_DIV - 1);
    else if (!mode || tick)
      pre_q <= PW'(TICK_DIV - 1);
    else
      pre_q <= pre_q - PW'(1);
  end

  // UI state, channel registers and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_q       <= UI_BROWSE;
      btn_prev   <= '1;
      sel        <= '0;
      field      <= 2'd0;
      running    <= '0;
      alm        <= '0;
      disp_hour  <= 7'd0;
      disp_min   <= 6'd0;
      disp_sec   <= 6'd0;
      blink_mask <= 6'b000000;
      norm       <= 1'b1;
      for (int i = 0; i < CH; i++) begin
        hour_q[i] <= 7'd0;
        min_q[i]  <= 6'd0;
        sec_q[i]  <= 6'd0;
`ifdef MULTI_TIMER_REPEAT_EN
        phour_q[i] <= 7'd0;
        pmin_q[i]  <= 6'd0;
        psec_q[i]  <= 6'd0;
`endif
      end
    end else begin
      ui_q      <= ui_n;
      btn_prev  <= btn;
      sel       <= sel_n;
      field     <= field_n;
      running   <= running_n;
      alm       <= alm_n;
      disp_hour <= hour_n[sel_n];
      disp_min  <= min_n[sel_n];
      disp_sec  <= sec_n[sel_n];
      norm      <= (field_n == 2'd0);
      case (field_n)
        2'd1:    blink_mask <= 6'b000011;
        2'd2:    blink_mask <= 6'b001100;
        2'd3:    blink_mask <= 6'b110000;
        default: blink_mask <= 6'b000000;
      endcase
      for (int i = 0; i < CH; i++) begin
        hour_q[i] <= hour_n[i];
        min_q[i]  <= min_n[i];
        sec_q[i]  <= sec_n[i];
`ifdef MULTI_TIMER_REPEAT_EN
        phour_q[i] <= phour_n[i];
        pmin_q[i]  <= pmin_n[i];
        psec_q[i]  <= psec_n[i];
`endif
      end
    end
  end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel countdown timer for the clock/alarm/stopwatch board design. Holds `CH` independent H:M:S countdown channels sharing one seconds prescaler, with a single button-driven UI for selecting, editing, starting, pausing and clearing channels. It outputs the selected channel's binary fields, a digit blink mask for the display stage, and per-channel sticky alarm flags. 7-segment encoding and blinking are done downstream.

## Interface
- `CH`, 4: number of channels, 2..8.
- `TICK_DIV`, 1000000: clk cycles per one-second tick.
- `HOUR_MAX`, 99: maximum hour value, 1..99.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mode` in 1: block enable; low clears everything.
- `up`, `down`, `left`, `right`, `enter`, `esc` in 1 each: button levels, already debounced and synchronous to `clk`.
- `sel` out SW (SW = clog2(CH)): selected channel index.
- `disp_hour` out 7 / `disp_min` out 6 / `disp_sec` out 6: fields of channel `sel`.
- `field` out 2: 0 browse, 1 sec, 2 min, 3 hour.
- `blink_mask` out 6: digit pairs {hour, min, sec}; 000011 sec, 001100 min, 110000 hour, 000000 browse.
- `norm` out 1: high when `field`==0.
- `running` out CH: channel counting.
- `alm` out CH: sticky expiry flag.

## Operation
- Press detection: a press is level high while the previous-cycle sample is low. Previous-sample registers reset to 1, so a button held through reset does not fire.
- At most one press acts per cycle. Priority: esc > enter > right > left > up > down.
- Prescaler: free-running 0..TICK_DIV-1. It emits a one-cycle tick at TICK_DIV-1 and is cleared by reset or `mode` low. A newly started channel first decrements 1..TICK_DIV cycles after start.
- Decrement on tick, for each running channel:
  - sec>0: sec-1.
  - Else min>0: min-1, sec=59.
  - Else: hour-1, min=59, sec=59.
- Expiry: the decrement that yields 00:00:00 sets `alm[i]` and clears `running[i]` in the same cycle.
- UI state browse (`field`=0):
  - up / down: `sel` +1 / -1, wrapping modulo CH.
  - right: start channel `sel` if it is stopped and nonzero. A zero value is ignored.
  - enter: pause channel `sel` if running. If stopped, enter the set state with `field`=1.
  - esc: channel `sel` goes to 0, stopped, preset 0, `alm[sel]` cleared.
  - left: no effect.
- UI state set (channel `sel` is always stopped here):
  - left rotates field 1→2→3→1; right rotates field 1→3→2→1.
  - up / down adjust the active field with wrap: sec 0..59, min 0..59, hour 0..HOUR_MAX.
  - enter: store current H:M:S as the channel's preset and return to `field`=0.
  - esc: clear the channel as in browse and return to `field`=0.
- `mode` low: all channels 0, stopped, preset 0. `alm`=0, `sel`=0, `field`=0, prescaler 0. Buttons are ignored.
- Same-cycle conflicts:
  - A UI action on channel `sel` overrides that channel's tick in that cycle; other channels still decrement.
  - Esc on a running channel at its expiry tick: channel cleared, `alm` stays 0.
  - An enter-pause coinciding with the expiry tick pauses the channel; no expiry.
- Alarms stay set until esc on that channel or `mode` low. Restarting a channel does not clear its alarm.

## Timing
- All outputs are registered. A press sampled at edge N is reflected in the outputs after edge N.
- A tick at edge N updates counts and `alm` after edge N.
- Reset values: `sel`=0, `disp_*`=0, `field`=0, `blink_mask`=0, `norm`=1, `running`=0, `alm`=0; all channel values and presets 0.
- `rst_n` asserted mid-count clears immediately, asynchronously. Release is synchronous to the next `clk` edge.

## Configuration
- `MULTI_TIMER_REPEAT_EN` defined: at expiry, a channel with a nonzero preset reloads the preset and stays running, and `alm[i]` is still set. A channel with a zero preset behaves as without the macro.
- Undefined: the channel stops at 00:00:00. Presets are not stored; set-state enter only returns to browse.

## Test plan
- Reset with `up` held high, then release `rst_n`: `sel` stays 0, `norm`=1, `alm`=0, all outputs 0.
- `TICK_DIV`=4. Set ch0 to 00:01:01 (enter, up, left, up, enter), then press right: ch0 reads 00:01:00, 00:00:59, …; at 00:00:00 `running[0]` falls and `alm[0]` rises on the same edge.
- Set ch0 to 01:00:00, then start it: the next tick gives 00:59:59. Adjust hour down from 0 in set state: hour reads HOUR_MAX.
- Start ch0 and ch1, press up (`sel`=1), then esc: ch1 clears while ch0 keeps counting. Press down from `sel`=0: `sel`=CH-1.
- Press enter and right in the same cycle while ch0 is running: only the pause happens. Press right on a 00:00:00 channel: it stays stopped.
- With `MULTI_TIMER_REPEAT_EN`, ch0 preset 00:00:02: after expiry `alm[0]`=1, the display reads 00:00:02, and `running[0]`=1.
